// File: rtl/sdram_pkg.sv
// Shared SDRAM bring-up definitions: checker state encoding, data width and
// mode-register burst-length decode used by both the writer and the read checker.
package sdram_pkg;

  localparam int unsigned SDR_DQ_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Mode-register BL field to words per burst; unsupported codes read as single beats.
  function automatic int unsigned bl_to_len(input logic [2:0] bl);
    case (bl)
      3'b001:  return 2;
      3'b010:  return 4;
      3'b011:  return 8;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Seed-loaded incrementing data pattern, shared by the writer and the read checker
// so both sides always agree on the expected word sequence.
module sdram_pattern_gen #(
  parameter int unsigned           WIDTH = 16,
  parameter logic [WIDTH-1:0]      SEED  = 'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = SEED;
    end else if (advance_i) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sdram_rd_checker.sv
// Checks the sdram_core read-return stream against the incrementing write pattern,
// counting mismatches, capturing the first one and flagging burst-length errors.
module sdram_rd_checker #(
  parameter int unsigned                  SDR_DQ_WIDTH  = sdram_pkg::SDR_DQ_WIDTH,
  parameter int unsigned                  BURST_LEN     = sdram_pkg::bl_to_len(3'b011),
  parameter int unsigned                  NUM_BURSTS    = 16,
  parameter logic [SDR_DQ_WIDTH-1:0]      SEED          = 'h1,
  parameter int unsigned                  ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [SDR_DQ_WIDTH-1:0]  rd_burst_data,
  input  logic                     rd_burst_data_valid,
  input  logic                     rd_burst_finish,
  output logic                     o_busy,
  output logic                     o_pass,
  output logic                     o_fail,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic                     o_len_err,
  output logic [15:0]              o_first_err_idx,
  output logic [SDR_DQ_WIDTH-1:0]  o_first_err_data,
  output logic [SDR_DQ_WIDTH-1:0]  o_first_err_exp,
  output logic                     o_led_receive_done
);

  import sdram_pkg::*;

  localparam logic [15:0] TOTAL_W = 16'(BURST_LEN * NUM_BURSTS);
  localparam logic [15:0] BL_W    = 16'(BURST_LEN);

  logic [1:0]               state_q, state_d;
  logic [15:0]              word_cnt_q, word_cnt_d;
  logic [15:0]              beat_cnt_q, beat_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     len_err_q, len_err_d;
  logic                     pass_q, pass_d;
  logic                     fail_q, fail_d;
  logic                     led_q;
  logic [15:0]              first_idx_q, first_idx_d;
  logic [SDR_DQ_WIDTH-1:0]  first_data_q, first_data_d;
  logic [SDR_DQ_WIDTH-1:0]  first_exp_q, first_exp_d;

  logic [SDR_DQ_WIDTH-1:0]  exp_val;
  logic                     pg_load, pg_adv;
  logic [15:0]              beats_now;

  sdram_pattern_gen #(
    .WIDTH (SDR_DQ_WIDTH),
    .SEED  (SEED)
  ) u_pattern_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pg_load),
    .advance_i (pg_adv),
    .value_o   (exp_val)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    err_cnt_d    = err_cnt_q;
    len_err_d    = len_err_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    first_exp_d  = first_exp_q;
    pg_load      = i_start;
    pg_adv       = 1'b0;
    beats_now    = beat_cnt_q + {15'd0, rd_burst_data_valid};

    // Start takes priority over any beat presented in the same cycle.
    if (i_start) begin
      state_d      = ST_RUN;
      word_cnt_d   = '0;
      beat_cnt_d   = '0;
      err_cnt_d    = '0;
      len_err_d    = 1'b0;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      first_idx_d  = '0;
      first_data_d = '0;
      first_exp_d  = '0;
    end else if (state_q == ST_RUN) begin
      if (rd_burst_data_valid) begin
        pg_adv     = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
        beat_cnt_d = beats_now;
        if (rd_burst_data != exp_val) begin
          if (err_cnt_q == '0) begin
            first_idx_d  = word_cnt_q;
            first_data_d = rd_burst_data;
            first_exp_d  = exp_val;
          end
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      // Length check sees the beat accepted in this same cycle.
      if (rd_burst_finish) begin
        if (beats_now != BL_W) begin
          len_err_d = 1'b1;
        end
        beat_cnt_d = '0;
      end
      fail_d = fail_q | len_err_d;
      if (rd_burst_data_valid && (word_cnt_d == TOTAL_W)) begin
        state_d = ST_DONE;
        pass_d  = (err_cnt_d == '0) && !len_err_d;
        fail_d  = (err_cnt_d != '0) || len_err_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
      len_err_q    <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      led_q        <= 1'b0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      first_exp_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
      len_err_q    <= len_err_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      led_q        <= pass_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      first_exp_q  <= first_exp_d;
    end
  end

  assign o_busy             = (state_q == ST_RUN);
  assign o_pass             = pass_q;
  assign o_fail             = fail_q;
  assign o_err_cnt          = err_cnt_q;
  assign o_len_err          = len_err_q;
  assign o_first_err_idx    = first_idx_q;
  assign o_first_err_data   = first_data_q;
  assign o_first_err_exp    = first_exp_q;
  assign o_led_receive_done = led_q;

endmodule

// File: tb/tb_sdram_rd_checker.sv
// Directed bench for sdram_rd_checker: a word-level scoreboard model checked every cycle,
// plus literal expectations for the main scenarios and two parameter variants.
module tb_sdram_rd_checker;

  localparam int BL     = 8;
  localparam int NB     = 16;
  localparam int TOTAL  = BL * NB;
  localparam int SEED   = 1;
  localparam int ERRMAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  logic        rd_finish = 1'b0;

  logic        busy, pass, fail, len_err, led;
  logic [15:0] err_cnt, fidx, fdata, fexp;

  logic        w_busy, w_pass, w_fail, w_len_err, w_led;
  logic [15:0] w_err_cnt, w_fidx, w_fdata, w_fexp;

  logic        s_busy, s_pass, s_fail, s_len_err, s_led;
  logic [3:0]  s_err_cnt;
  logic [15:0] s_fidx, s_fdata, s_fexp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_rd_checker dut (
    .clk(clk), .rst(rst), .i_start(i_start), .rd_burst_data(rd_data),
    .rd_burst_data_valid(rd_valid), .rd_burst_finish(rd_finish),
    .o_busy(busy), .o_pass(pass), .o_fail(fail), .o_err_cnt(err_cnt), .o_len_err(len_err),
    .o_first_err_idx(fidx), .o_first_err_data(fdata), .o_first_err_exp(fexp),
    .o_led_receive_done(led)
  );

  sdram_rd_checker #(.SEED(16'hFFFC), .NUM_BURSTS(1)) dut_w (
    .clk(clk), .rst(rst), .i_start(i_start), .rd_burst_data(rd_data),
    .rd_burst_data_valid(rd_valid), .rd_burst_finish(rd_finish),
    .o_busy(w_busy), .o_pass(w_pass), .o_fail(w_fail), .o_err_cnt(w_err_cnt),
    .o_len_err(w_len_err), .o_first_err_idx(w_fidx), .o_first_err_data(w_fdata),
    .o_first_err_exp(w_fexp), .o_led_receive_done(w_led)
  );

  sdram_rd_checker #(.ERR_CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .i_start(i_start), .rd_burst_data(rd_data),
    .rd_burst_data_valid(rd_valid), .rd_burst_finish(rd_finish),
    .o_busy(s_busy), .o_pass(s_pass), .o_fail(s_fail), .o_err_cnt(s_err_cnt),
    .o_len_err(s_len_err), .o_first_err_idx(s_fidx), .o_first_err_data(s_fdata),
    .o_first_err_exp(s_fexp), .o_led_receive_done(s_led)
  );

  // Scoreboard model for the default-parameter instance.
  bit m_run, m_first, m_len, m_pass, m_fail;
  int m_exp, m_words, m_beats, m_err, m_idx, m_fdata, m_fexp;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, expv);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_first = 0; m_len = 0; m_pass = 0; m_fail = 0;
    m_exp = SEED; m_words = 0; m_beats = 0; m_err = 0;
    m_idx = 0; m_fdata = 0; m_fexp = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit f, input int d);
    if (s) begin
      model_clear();
      m_run = 1;
    end else if (m_run) begin
      if (v) begin
        if (d != m_exp) begin
          if (!m_first) begin
            m_first = 1; m_idx = m_words; m_fdata = d; m_fexp = m_exp;
          end
          if (m_err < ERRMAX) m_err++;
        end
        m_exp = (m_exp + 1) % 65536;
        m_words++;
        m_beats++;
      end
      if (f) begin
        if (m_beats != BL) m_len = 1;
        m_beats = 0;
      end
      if (m_len) m_fail = 1;
      if (m_words == TOTAL) begin
        m_run  = 0;
        m_pass = (m_err == 0) && !m_len;
        m_fail = (m_err != 0) || m_len;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy",      32'(busy),    32'(m_run));
      chk("pass",      32'(pass),    32'(m_pass));
      chk("fail",      32'(fail),    32'(m_fail));
      chk("led",       32'(led),     32'(m_pass));
      chk("len_err",   32'(len_err), 32'(m_len));
      chk("err_cnt",   32'(err_cnt), 32'(m_err));
      chk("first_idx", 32'(fidx),    32'(m_idx));
      chk("first_dat", 32'(fdata),   32'(m_fdata));
      chk("first_exp", 32'(fexp),    32'(m_fexp));
    end
  end

  task automatic step(input bit s, input bit v, input bit f, input logic [15:0] d);
    i_start = s; rd_valid = v; rd_finish = f; rd_data = d;
    @(posedge clk);
    model_step(s, v, f, int'(d));
    #1;
    i_start = 0; rd_valid = 0; rd_finish = 0; rd_data = '0;
  endtask

  // Word w carries seed+w; optional single corruption, short burst, all-inverted, early stop.
  task automatic send_stream(input int seed, input int nbursts, input int bad_idx,
                             input logic [15:0] bad_val, input int short_burst,
                             input bit all_bad, input int stop_at);
    int w = 0;
    logic [15:0] d;
    for (int b = 0; b < nbursts; b++) begin
      int len = (b == short_burst) ? BL - 1 : BL;
      for (int k = 0; k < len; k++) begin
        if (w == stop_at) return;
        d = 16'((seed + w) % 65536);
        if (all_bad) d = ~d;
        if (w == bad_idx) d = bad_val;
        step(0, 1, (k == len - 1), d);
        w++;
      end
      if (b % 2 == 1) step(0, 0, 0, 16'h0);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err",  32'(err_cnt), 0);
    chk("rst_idx",  32'(fidx), 0);
    rst = 0;

    // Beats before any start are ignored.
    step(0, 1, 0, 16'h1234);
    step(0, 1, 1, 16'h0001);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_err",  32'(err_cnt), 0);
    chk("idle_len",  32'(len_err), 0);

    // Clean pass.
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, -1, 16'h0, -1, 0, -1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_led",  32'(led), 1);
    chk("t1_fail", 32'(fail), 0);
    chk("t1_err",  32'(err_cnt), 0);
    chk("t1_busy", 32'(busy), 0);

    // Single corrupted word.
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, 37, 16'hDEAD, -1, 0, -1);
    chk("t2_err",  32'(err_cnt), 1);
    chk("t2_idx",  32'(fidx), 37);
    chk("t2_data", 32'(fdata), 32'h0000DEAD);
    chk("t2_exp",  32'(fexp), 32'h00000026);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_pass", 32'(pass), 0);

    // Burst 3 (0-based) ends after 7 beats.
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, -1, 16'h0, 3, 0, 31);
    chk("t3_len_now",  32'(len_err), 1);
    chk("t3_fail_now", 32'(fail), 1);
    chk("t3_busy_now", 32'(busy), 1);
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, -1, 16'h0, 3, 0, -1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_fail", 32'(fail), 1);
    chk("t3_busy", 32'(busy), 1);

    // Wrap across FFFF -> 0000 on the SEED=FFFC, single-burst instance.
    step(1, 0, 0, 16'h0);
    send_stream(32'hFFFC, 1, -1, 16'h0, -1, 0, -1);
    chk("t4_w_pass", 32'(w_pass), 1);
    chk("t4_w_err",  32'(w_err_cnt), 0);
    chk("t4_w_fail", 32'(w_fail), 0);
    chk("t4_w_led",  32'(w_led), 1);

    // Every word wrong; narrow counter saturates.
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, -1, 16'h0, -1, 1, -1);
    chk("t5_err",   32'(err_cnt), 128);
    chk("t5_idx",   32'(fidx), 0);
    chk("t5_data",  32'(fdata), 32'h0000FFFE);
    chk("t5_exp",   32'(fexp), 1);
    chk("t5_s_err", 32'(s_err_cnt), 15);
    chk("t5_s_fail", 32'(s_fail), 1);

    // Async reset mid burst 5 with an error already recorded.
    step(1, 0, 0, 16'h0);
    send_stream(SEED, NB, 2, 16'h5555, -1, 0, 35);
    chk("t6_pre_err", 32'(err_cnt), 1);
    #2;
    rst = 1;
    model_clear();
    #1;
    chk("t6_busy",  32'(busy), 0);
    chk("t6_err",   32'(err_cnt), 0);
    chk("t6_idx",   32'(fidx), 0);
    chk("t6_data",  32'(fdata), 0);
    chk("t6_exp",   32'(fexp), 0);
    chk("t6_fail",  32'(fail), 0);
    chk("t6_s_busy", 32'(s_busy), 0);
    @(posedge clk);
    #1;
    rst = 0;

    // Start coincident with a beat drops that beat; clean stream must still pass.
    step(1, 1, 0, 16'h0001);
    chk("t6_drop_busy", 32'(busy), 1);
    send_stream(SEED, NB, -1, 16'h0, -1, 0, -1);
    chk("t6_pass", 32'(pass), 1);
    chk("t6_err2", 32'(err_cnt), 0);

    step(0, 0, 0, 16'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
